// File: rtl/rf_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wr_arbiter_pkg
//   Shared constants and types for the register-file write arbiter: data
//   width, register index width, register count and the buffered
//   long-latency result entry.
// ----------------------------------------------------------------------------
package rf_wr_arbiter_pkg;

  // Architectural data width.
  localparam int XLEN   = 32;
  // Register index width and register count.
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xdata_t;
  typedef logic [NREG-1:0]   reg_mask_t;

  // One buffered long-unit result: destination register plus its data.
  typedef struct packed {
    reg_idx_t rd;
    xdata_t   wd;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes aimed at it are dropped.
  function automatic logic is_x0(input reg_idx_t r);
    return (r == '0);
  endfunction

  // One-hot decode of a register index into a scoreboard mask.
  function automatic reg_mask_t reg_onehot(input reg_idx_t r);
    reg_mask_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage : rf_wr_arbiter_pkg

// File: rtl/rf_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_wr_arbiter_if
//   Bundles every signal between the arbiter and its neighbours: the WB stage
//   write request, the long-unit result stream, long-op issue, hazard queries
//   and the register-file write port.
//   master : pipeline / long unit / hazard unit / register file side
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface rf_wr_arbiter_if;
  import rf_wr_arbiter_pkg::*;

  // WB stage write request
  logic     pipe_we;
  reg_idx_t pipe_rd;
  xdata_t   pipe_wd;
  logic     pipe_ready;

  // Long-unit result stream
  logic     lu_valid;
  reg_idx_t lu_rd;
  xdata_t   lu_wd;
  logic     lu_ready;

  // Long-op issue (marks destination busy)
  logic     iss_valid;
  reg_idx_t iss_rd;

  // Hazard-unit queries and answers
  reg_idx_t chk_rs1;
  reg_idx_t chk_rs2;
  reg_idx_t chk_rd;
  logic     busy_rs1;
  logic     busy_rs2;
  logic     busy_rd;

  // Register-file write port
  logic     rf_we;
  reg_idx_t rf_wR;
  xdata_t   rf_wD;

  modport master (
    output pipe_we, pipe_rd, pipe_wd,
    input  pipe_ready,
    output lu_valid, lu_rd, lu_wd,
    input  lu_ready,
    output iss_valid, iss_rd,
    output chk_rs1, chk_rs2, chk_rd,
    input  busy_rs1, busy_rs2, busy_rd,
    input  rf_we, rf_wR, rf_wD
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd,
    output pipe_ready,
    input  lu_valid, lu_rd, lu_wd,
    output lu_ready,
    input  iss_valid, iss_rd,
    input  chk_rs1, chk_rs2, chk_rd,
    output busy_rs1, busy_rs2, busy_rd,
    output rf_we, rf_wR, rf_wD
  );

endinterface : rf_wr_arbiter_if

// File: rtl/rf_wr_arbiter_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO holding long-unit results until the register file
//   write port is free. Pointers carry one extra wrap bit, so full and empty
//   come straight from registered state (no same-cycle pass-through).
//   The head entry is visible combinationally; pop_i consumes it at the edge.
// ----------------------------------------------------------------------------
module wb_fifo
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  wb_entry_t   mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  // Same index with different wrap bits means the writer lapped the reader.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Guard the strobes locally so a misbehaving caller cannot corrupt pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Next pointer values; each pointer advances independently and wraps naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers, cleared by reset so the FIFO comes up empty.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage, written on push.
  // NOTE: storage has no reset; empty pointers already mark every entry invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule : wb_fifo

// File: rtl/rf_wr_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wr_arbiter
//   Shares the register file's single write port between the in-order WB
//   stage and the long-latency unit (load/div). Long results wait in wb_fifo
//   so the pipe never stalls on them; the pipe normally has priority, but
//   after STARVE_MAX consecutive pipe wins with a non-empty FIFO the FIFO
//   head is forced through and the WB stage is held for one cycle.
//   A busy scoreboard marks registers with an outstanding long write so the
//   hazard unit can stall readers and WAW writers.
// ----------------------------------------------------------------------------
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_wr_arbiter_if.slave   bus
);

  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // FIFO interface
  wb_entry_t fifo_head;
  wb_entry_t fifo_in;
  logic      fifo_empty;
  logic      fifo_full;
  logic      fifo_push;
  logic      fifo_pop;

  // Arbitration
  logic      force_fifo;
  logic      pipe_win;
  logic      fifo_win;

  // Write-port mux
  logic      rf_we;
  reg_idx_t  rf_wr;
  xdata_t    rf_wd;

  // State
  logic [SW-1:0] starve_q, starve_d;
  reg_mask_t     busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Long-result FIFO. lu_ready reflects registered full only, so a result
  // always spends at least one cycle buffered before reaching the rf.
  // --------------------------------------------------------------------------
  assign bus.lu_ready = rst_n && !fifo_full;
  assign fifo_push    = bus.lu_valid && bus.lu_ready;
  assign fifo_in      = '{rd: bus.lu_rd, wd: bus.lu_wd};
  assign fifo_pop     = fifo_win;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Pick the port owner: pipe first unless the FIFO has starved long enough.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    force_fifo = 1'b0;
    pipe_win   = 1'b0;
    fifo_win   = 1'b0;
    if (rst_n) begin
      force_fifo = (starve_q == STARVE_LIM) && !fifo_empty;
      pipe_win   = !force_fifo && bus.pipe_we;
      fifo_win   = !fifo_empty && (force_fifo || !bus.pipe_we);
    end
  end

  // Drive the rf write port from the winner; x0-destined FIFO entries still pop but never write.
  always_comb begin
    rf_we = 1'b0;
    rf_wr = bus.pipe_rd;
    rf_wd = bus.pipe_wd;
    if (pipe_win) begin
      rf_we = 1'b1;
    end else if (fifo_win) begin
      rf_we = !is_x0(fifo_head.rd);
      rf_wr = fifo_head.rd;
      rf_wd = fifo_head.wd;
    end
  end

  assign bus.rf_we      = rf_we;
  assign bus.rf_wR      = rf_wr;
  assign bus.rf_wD      = rf_wd;
  assign bus.pipe_ready = rst_n && !force_fifo;

  // Count consecutive pipe wins while the FIFO waits; any pop or an empty FIFO restarts it.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Scoreboard update: pop clears the popped rd, issue sets iss_rd; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d = busy_d & ~reg_onehot(fifo_head.rd);
    end
    if (bus.iss_valid && !is_x0(bus.iss_rd)) begin
      busy_d = busy_d | reg_onehot(bus.iss_rd);
    end
    busy_d[0] = 1'b0;
  end

  // Starve counter and scoreboard registers; reset discards all pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  // Hazard-unit answers are plain lookups into the registered scoreboard.
  assign bus.busy_rs1 = busy_q[bus.chk_rs1];
  assign bus.busy_rs2 = busy_q[bus.chk_rs2];
  assign bus.busy_rd  = busy_q[bus.chk_rd];

endmodule : rf_wr_arbiter

// File: tb/tb_rf_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wr_arbiter
//   Directed bench for rf_wr_arbiter (DEPTH=2, STARVE_MAX=4). Inputs change
//   1 time unit after the rising edge; outputs are sampled mid-cycle.
// ----------------------------------------------------------------------------
module tb_rf_wr_arbiter;
  import rf_wr_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rf_wr_arbiter_if bus ();

  rf_wr_arbiter #(
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log a mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Deassert all request inputs; hazard query indices are left alone.
  task automatic idle();
    bus.pipe_we   = 1'b0;
    bus.pipe_rd   = '0;
    bus.pipe_wd   = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_wd     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] wd);
    bus.pipe_we = 1'b1;
    bus.pipe_rd = rd;
    bus.pipe_wd = wd;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [31:0] wd);
    bus.lu_valid = 1'b1;
    bus.lu_rd    = rd;
    bus.lu_wd    = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus.chk_rs1 = '0;
    bus.chk_rs2 = '0;
    bus.chk_rd  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- 1: reset behaviour ----
    pipe(5'd1, 32'h1);
    lu(5'd2, 32'h2);
    #1;
    check("rst_rf_we",      32'(bus.rf_we),      32'h0);
    check("rst_lu_ready",   32'(bus.lu_ready),   32'h0);
    check("rst_pipe_ready", 32'(bus.pipe_ready), 32'h0);
    idle();
    rst_n = 1'b1;
    step();
    // traffic in flight, then reset again mid-operation
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    lu(5'd4, 32'h55);
    bus.chk_rs1 = 5'd3;
    step();
    idle();
    #1;
    check("pre_rst_busy3",  32'(bus.busy_rs1), 32'h1);
    check("pre_rst_head",   32'(bus.rf_wR),    32'h4);
    rst_n = 1'b0;
    pipe(5'd1, 32'h1);
    #1;
    check("mid_rst_rf_we",  32'(bus.rf_we),    32'h0);
    check("mid_rst_busy3",  32'(bus.busy_rs1), 32'h0);
    check("mid_rst_lu_rdy", 32'(bus.lu_ready), 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    #1;
    check("post_rst_rf_we",   32'(bus.rf_we),      32'h0);
    check("post_rst_lu_rdy",  32'(bus.lu_ready),   32'h1);
    check("post_rst_pipe_rdy",32'(bus.pipe_ready), 32'h1);
    check("post_rst_busy3",   32'(bus.busy_rs1),   32'h0);
    step();

    // ---- 2: pipe-only write ----
    pipe(5'd5, 32'h1234);
    #1;
    check("pipe_we",    32'(bus.rf_we),      32'h1);
    check("pipe_wR",    32'(bus.rf_wR),      32'h5);
    check("pipe_wD",    bus.rf_wD,           32'h1234);
    check("pipe_ready", 32'(bus.pipe_ready), 32'h1);
    step();
    idle();

    // ---- 3: long op rd=7 ----
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.chk_rs1 = 5'd7; bus.chk_rs2 = 5'd7; bus.chk_rd = 5'd7;
    #1;
    check("lo_busy_before", 32'(bus.busy_rs1), 32'h0);
    step();
    idle();
    #1;
    check("lo_busy_rs1", 32'(bus.busy_rs1), 32'h1);
    check("lo_busy_rs2", 32'(bus.busy_rs2), 32'h1);
    check("lo_busy_rd",  32'(bus.busy_rd),  32'h1);
    step();
    #1;
    check("lo_busy_c2", 32'(bus.busy_rs1), 32'h1);
    step();
    lu(5'd7, 32'hCAFE);
    #1;
    check("lo_no_bypass", 32'(bus.rf_we),    32'h0);
    check("lo_lu_ready",  32'(bus.lu_ready), 32'h1);
    check("lo_busy_push", 32'(bus.busy_rs1), 32'h1);
    step();
    idle();
    #1;
    check("lo_wr_we",       32'(bus.rf_we),    32'h1);
    check("lo_wr_wR",       32'(bus.rf_wR),    32'h7);
    check("lo_wr_wD",       bus.rf_wD,         32'hCAFE);
    check("lo_busy_at_pop", 32'(bus.busy_rs1), 32'h1);
    step();
    #1;
    check("lo_busy_clear", 32'(bus.busy_rs1), 32'h0);
    check("lo_idle_we",    32'(bus.rf_we),    32'h0);

    // ---- 4: contention / starvation ----
    pipe(5'd1, 32'h100);
    lu(5'd10, 32'hA0A0);
    #1;
    check("st_p0_wR", 32'(bus.rf_wR), 32'h1);
    step();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pipe(5'(k + 1), 32'h100 + 32'(k));
      #1;
      check($sformatf("st_win%0d_rdy", k), 32'(bus.pipe_ready), 32'h1);
      check($sformatf("st_win%0d_wR", k),  32'(bus.rf_wR),      32'(k + 1));
      step();
    end
    pipe(5'd6, 32'h105);
    #1;
    check("st_force_rdy", 32'(bus.pipe_ready), 32'h0);
    check("st_force_we",  32'(bus.rf_we),      32'h1);
    check("st_force_wR",  32'(bus.rf_wR),      32'd10);
    check("st_force_wD",  bus.rf_wD,           32'hA0A0);
    step();
    #1;
    check("st_hold_rdy", 32'(bus.pipe_ready), 32'h1);
    check("st_hold_wR",  32'(bus.rf_wR),      32'h6);
    check("st_hold_wD",  bus.rf_wD,           32'h105);
    step();
    idle();

    // ---- 5: FIFO full, ordering, simultaneous push/pop ----
    pipe(5'd1, 32'h200);
    lu(5'd11, 32'hB1);
    #1;
    check("ff_c0_lu_rdy", 32'(bus.lu_ready), 32'h1);
    step();
    lu(5'd12, 32'hB2);
    #1;
    check("ff_c1_lu_rdy", 32'(bus.lu_ready), 32'h1);
    check("ff_c1_wR",     32'(bus.rf_wR),    32'h1);
    step();
    lu(5'd13, 32'hB3);
    #1;
    check("ff_full_lu_rdy", 32'(bus.lu_ready), 32'h0);
    step();
    #1;
    check("ff_c3_lu_rdy",   32'(bus.lu_ready),   32'h0);
    check("ff_c3_pipe_rdy", 32'(bus.pipe_ready), 32'h1);
    step();
    #1;
    check("ff_c4_pipe_rdy", 32'(bus.pipe_ready), 32'h1);
    step();
    #1;
    check("ff_c5_pipe_rdy", 32'(bus.pipe_ready), 32'h0);
    check("ff_c5_wR",       32'(bus.rf_wR),      32'd11);
    check("ff_c5_wD",       bus.rf_wD,           32'hB1);
    check("ff_c5_lu_rdy",   32'(bus.lu_ready),   32'h0);
    step();
    bus.pipe_we = 1'b0;
    #1;
    check("ff_c6_lu_rdy", 32'(bus.lu_ready), 32'h1);
    check("ff_c6_wR",     32'(bus.rf_wR),    32'd12);
    check("ff_c6_wD",     bus.rf_wD,         32'hB2);
    step();
    idle();
    #1;
    check("ff_c7_wR",     32'(bus.rf_wR),    32'd13);
    check("ff_c7_wD",     bus.rf_wD,         32'hB3);
    check("ff_c7_lu_rdy", 32'(bus.lu_ready), 32'h1);
    step();
    #1;
    check("ff_c8_we", 32'(bus.rf_we), 32'h0);

    // ---- 6: edge cases ----
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    bus.chk_rs1 = 5'd9;
    step();
    idle();
    lu(5'd9, 32'h99);
    #1;
    check("e_busy9", 32'(bus.busy_rs1), 32'h1);
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1;
    check("e_pop9_we", 32'(bus.rf_we), 32'h1);
    check("e_pop9_wR", 32'(bus.rf_wR), 32'h9);
    step();
    idle();
    #1;
    check("e_set_wins", 32'(bus.busy_rs1), 32'h1);
    lu(5'd9, 32'h98);
    step();
    idle();
    #1;
    check("e_pop9b_wR", 32'(bus.rf_wR), 32'h9);
    step();
    #1;
    check("e_busy9_clr", 32'(bus.busy_rs1), 32'h0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    bus.chk_rd = 5'd0;
    step();
    idle();
    #1;
    check("e_busy0", 32'(bus.busy_rd), 32'h0);
    lu(5'd0, 32'hDEAD);
    step();
    lu(5'd14, 32'hE);
    #1;
    check("e_x0_no_write", 32'(bus.rf_we), 32'h0);
    step();
    idle();
    #1;
    check("e_after_x0_we", 32'(bus.rf_we), 32'h1);
    check("e_after_x0_wR", 32'(bus.rf_wR), 32'd14);
    check("e_after_x0_wD", bus.rf_wD,      32'hE);
    step();
    #1;
    check("e_final_idle", 32'(bus.rf_we), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rf_wr_arbiter
